traffic_phase_ctrl: RTL and testbench

Phase sequencer for a four-approach intersection. It runs a fixed eight-phase cycle with programmable per-phase durations, collects pedestrian push-button requests, and stretches the matching green to serve them. It also preempts the cycle for an emergency vehicle. The block drives the lamp vectors consumed by the intersection lamp drivers and sits between the 1 Hz tick generator and the lamp output stage.

---
 rtl/traffic_pkg.sv | 46 ++++
 rtl/traffic_phase_ctrl_timer.sv | 41 ++++
 rtl/traffic_phase_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and constants for the intersection phase sequencer.
//   phase_e    - 3-bit phase code driven on the phase output
//   axis_e     - approach axis (NS/SN or EW/WE)
//   LAMP_*     - {lt,r,y,g} lamp patterns
//   lamp_decode- lamp pattern for one axis given the phase and the preempted axis
package traffic_pkg;

  typedef enum logic [2:0] {
    PhAr   = 3'd0,
    PhNsG  = 3'd1,
    PhNsY  = 3'd2,
    PhEwLt = 3'd3,
    PhEwG  = 3'd4,
    PhEwY  = 3'd5,
    PhNsLt = 3'd6,
    PhEmg  = 3'd7
  } phase_e;

  typedef enum logic {
    AxisNs = 1'b0,
    AxisEw = 1'b1
  } axis_e;

  localparam logic [3:0] LAMP_RED = 4'b0100;
  localparam logic [3:0] LAMP_GRN = 4'b0001;
  localparam logic [3:0] LAMP_YEL = 4'b0010;
  localparam logic [3:0] LAMP_LT  = 4'b1100;

  // Lamp pattern for 'side'; every axis not explicitly lit is red.
  function automatic logic [3:0] lamp_decode(phase_e ph, axis_e emg_axis, axis_e side);
    logic [3:0] lamp;
    lamp = LAMP_RED;
    unique case (ph)
      PhNsG:   if (side == AxisNs) lamp = LAMP_GRN;
      PhNsY:   if (side == AxisNs) lamp = LAMP_YEL;
      PhNsLt:  if (side == AxisNs) lamp = LAMP_LT;
      PhEwG:   if (side == AxisEw) lamp = LAMP_GRN;
      PhEwY:   if (side == AxisEw) lamp = LAMP_YEL;
      PhEwLt:  if (side == AxisEw) lamp = LAMP_LT;
      PhEmg:   if (side == emg_axis) lamp = LAMP_GRN;
      default: lamp = LAMP_RED;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_timer.sv
// phase_timer: tick-enabled phase duration counter.
//   clk, rst_n - clock, asynchronous active-low reset
//   tick       - count enable
//   clr        - synchronous clear (phase change); has priority over tick
//   dur        - duration of the current phase in ticks (>= 1)
//   tc         - terminal count: high on the tick where the count equals dur-1
module phase_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          clr,
  input  logic [TW-1:0] dur,
  output logic          tc
);

  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] last;

  assign last = dur - TW'(1);
  assign tc   = tick && (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: eight-phase sequencer for a four-approach intersection with
// pedestrian green extension and emergency preemption.
//   clk, rst_n       - clock, asynchronous active-low reset
//   tick             - timebase enable; phase timer advances only when high
//   ped_req[3:0]     - push buttons {WE,EW,SN,NS}
//   emg_req, emg_dir - preemption request (level) and axis (0=NS, 1=EW)
//   phase[2:0]       - current phase code
//   lamp_ns, lamp_ew - {lt,r,y,g} per axis
//   walk[1:0]        - {ew,ns} walk signals
//   ped_pend[3:0]    - latched pending pedestrian requests
//   emg_ack          - high while in the emergency phase
// GREEN_T+PED_EXT must fit in TW bits.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_T  = 40,
  parameter int unsigned LEFT_T   = 20,
  parameter int unsigned YEL_T    = 5,
  parameter int unsigned ALLRED_T = 2,
  parameter int unsigned PED_EXT  = 10,
  parameter int unsigned TW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] ped_req,
  input  logic       emg_req,
  input  logic       emg_dir,
  output logic [2:0] phase,
  output logic [3:0] lamp_ns,
  output logic [3:0] lamp_ew,
  output logic [1:0] walk,
  output logic [3:0] ped_pend,
  output logic       emg_ack
);

  localparam logic [TW-1:0] GreenDur  = TW'(GREEN_T);
  localparam logic [TW-1:0] GreenExt  = TW'(GREEN_T + PED_EXT);
  localparam logic [TW-1:0] LeftDur   = TW'(LEFT_T);
  localparam logic [TW-1:0] YelDur    = TW'(YEL_T);
  localparam logic [TW-1:0] AllredDur = TW'(ALLRED_T);

  phase_e     phase_q, phase_d;
  phase_e     nxt_q, nxt_d;       // phase that follows the next AR
  axis_e      axis_q, axis_d;     // preempted axis
  logic       emg_pend_q, emg_pend_d;
  logic [1:0] walk_q, walk_d;
  logic [3:0] ped_pend_q, ped_pend_d;
  logic [3:0] lamp_ns_q, lamp_ns_d;
  logic [3:0] lamp_ew_q, lamp_ew_d;
  logic       emg_ack_q, emg_ack_d;

  logic          accept;
  logic          pend_eff;
  axis_e         axis_eff;
  logic [3:0]    ped_clr;
  logic [TW-1:0] dur;
  logic          tc;
  logic          clr;

  // A new request is acted on in the same cycle it is sampled, so green/left
  // phases leave on the very next edge rather than one cycle after the latch.
  assign accept   = emg_req && !emg_pend_q && (phase_q != PhEmg);
  assign pend_eff = emg_pend_q || accept;
  assign axis_eff = emg_pend_q ? axis_q : axis_e'(emg_dir);
  assign clr      = (phase_d != phase_q);

  always_comb begin
    dur = '1;
    unique case (phase_q)
      PhNsG:          dur = walk_q[0] ? GreenExt : GreenDur;
      PhEwG:          dur = walk_q[1] ? GreenExt : GreenDur;
      PhNsLt, PhEwLt: dur = LeftDur;
      PhNsY, PhEwY:   dur = YelDur;
      PhAr:           dur = AllredDur;
      default:        dur = '1; // EMG exits on emg_req, not the timer
    endcase
  end

  phase_timer #(
    .TW(TW)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .clr  (clr),
    .dur  (dur),
    .tc   (tc)
  );

  // Next-state logic
  always_comb begin
    phase_d    = phase_q;
    nxt_d      = nxt_q;
    axis_d     = accept ? axis_e'(emg_dir) : axis_q;
    emg_pend_d = pend_eff;

    unique case (phase_q)
      PhNsG, PhNsLt: begin
        if (pend_eff) begin
          phase_d = (axis_eff == AxisNs) ? PhEmg : PhNsY;
        end else if (tc) begin
          phase_d = (phase_q == PhNsG) ? PhNsY : PhNsG;
        end
      end
      PhEwG, PhEwLt: begin
        if (pend_eff) begin
          phase_d = (axis_eff == AxisEw) ? PhEmg : PhEwY;
        end else if (tc) begin
          phase_d = (phase_q == PhEwLt) ? PhEwG : PhEwY;
        end
      end
      PhNsY: begin
        if (tc) begin
          phase_d = PhAr;
          nxt_d   = PhEwLt;
        end
      end
      PhEwY: begin
        if (tc) begin
          phase_d = PhAr;
          nxt_d   = PhNsLt;
        end
      end
      PhAr: begin
        if (tc) begin
          phase_d = pend_eff ? PhEmg : nxt_q;
        end
      end
      PhEmg: begin
        // Leaving through the preempted axis' yellow sets nxt to the other left.
        if (tick && !emg_req) begin
          phase_d = (axis_q == AxisNs) ? PhNsY : PhEwY;
        end
      end
      default: phase_d = PhAr;
    endcase

    if ((phase_d == PhEmg) && (phase_q != PhEmg)) begin
      emg_pend_d = 1'b0;
    end
  end

  // Pedestrian latch and walk: served only on green entry; set beats clear.
  always_comb begin
    walk_d  = walk_q;
    ped_clr = '0;
    if (phase_d != phase_q) begin
      walk_d = '0;
      if (phase_d == PhNsG) begin
        walk_d[0]    = |ped_pend_q[1:0];
        ped_clr[1:0] = 2'b11;
      end
      if (phase_d == PhEwG) begin
        walk_d[1]    = |ped_pend_q[3:2];
        ped_clr[3:2] = 2'b11;
      end
    end
    ped_pend_d = (ped_pend_q & ~ped_clr) | ped_req;
  end

  // Registered Moore outputs, decoded from the next state so they move with it.
  always_comb begin
    lamp_ns_d = lamp_decode(phase_d, axis_d, AxisNs);
    lamp_ew_d = lamp_decode(phase_d, axis_d, AxisEw);
    emg_ack_d = (phase_d == PhEmg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= PhAr;
      nxt_q      <= PhNsG;
      axis_q     <= AxisNs;
      emg_pend_q <= 1'b0;
      walk_q     <= '0;
      ped_pend_q <= '0;
      lamp_ns_q  <= LAMP_RED;
      lamp_ew_q  <= LAMP_RED;
      emg_ack_q  <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      nxt_q      <= nxt_d;
      axis_q     <= axis_d;
      emg_pend_q <= emg_pend_d;
      walk_q     <= walk_d;
      ped_pend_q <= ped_pend_d;
      lamp_ns_q  <= lamp_ns_d;
      lamp_ew_q  <= lamp_ew_d;
      emg_ack_q  <= emg_ack_d;
    end
  end

  assign phase    = phase_q;
  assign lamp_ns  = lamp_ns_q;
  assign lamp_ew  = lamp_ew_q;
  assign walk     = walk_q;
  assign ped_pend = ped_pend_q;
  assign emg_ack  = emg_ack_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: table-driven directed bench for traffic_phase_ctrl.
// Each vector drives inputs, then checks the outputs after each of 'len' clock edges.
module tb_traffic_phase_ctrl;

  localparam logic [3:0] R = 4'b0100;
  localparam logic [3:0] G = 4'b0001;
  localparam logic [3:0] Y = 4'b0010;
  localparam logic [3:0] L = 4'b1100;

  localparam logic [2:0] PAR  = 3'd0;
  localparam logic [2:0] PNG  = 3'd1;
  localparam logic [2:0] PNY  = 3'd2;
  localparam logic [2:0] PELT = 3'd3;
  localparam logic [2:0] PEG  = 3'd4;
  localparam logic [2:0] PEY  = 3'd5;
  localparam logic [2:0] PNLT = 3'd6;
  localparam logic [2:0] PEMG = 3'd7;

  typedef struct {
    logic [3:0] ped;
    logic       emg;
    logic       dir;
    logic [2:0] ph;
    int         len;
    logic [3:0] ns;
    logic [3:0] ew;
    logic [1:0] wk;
    logic [3:0] pend;
    logic       ack;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [3:0] ped_req;
  logic       emg_req;
  logic       emg_dir;
  logic [2:0] phase;
  logic [3:0] lamp_ns;
  logic [3:0] lamp_ew;
  logic [1:0] walk;
  logic [3:0] ped_pend;
  logic       emg_ack;

  int checks = 0;
  int errors = 0;
  vec_t tv[$];

  traffic_phase_ctrl #(
    .GREEN_T (40),
    .LEFT_T  (20),
    .YEL_T   (5),
    .ALLRED_T(2),
    .PED_EXT (10),
    .TW      (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .ped_req (ped_req),
    .emg_req (emg_req),
    .emg_dir (emg_dir),
    .phase   (phase),
    .lamp_ns (lamp_ns),
    .lamp_ew (lamp_ew),
    .walk    (walk),
    .ped_pend(ped_pend),
    .emg_ack (emg_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(logic [3:0] ped, logic emg, logic dir, logic [2:0] ph, int len,
                             logic [3:0] ns, logic [3:0] ew, logic [1:0] wk, logic [3:0] pend,
                             logic ack);
    vec_t r;
    r.ped = ped; r.emg = emg; r.dir = dir; r.ph = ph; r.len = len;
    r.ns = ns; r.ew = ew; r.wk = wk; r.pend = pend; r.ack = ack;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input vec_t e);
    chk({tag, " phase"}, 8'(phase), 8'(e.ph));
    chk({tag, " lamp_ns"}, 8'(lamp_ns), 8'(e.ns));
    chk({tag, " lamp_ew"}, 8'(lamp_ew), 8'(e.ew));
    chk({tag, " walk"}, 8'(walk), 8'(e.wk));
    chk({tag, " ped_pend"}, 8'(ped_pend), 8'(e.pend));
    chk({tag, " emg_ack"}, 8'(emg_ack), 8'(e.ack));
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ped_req = tv[i].ped;
      emg_req = tv[i].emg;
      emg_dir = tv[i].dir;
      for (int k = 0; k < tv[i].len; k++) begin
        @(posedge clk);
        #1;
        chk_outputs($sformatf("v%0d.%0d", i, k), tv[i]);
      end
    end
  endtask

  initial begin
    vec_t rst_exp;
    int   g_cnt;
    int   y_cnt;
    logic done;

    // Lap 1: plain cycle after reset (0..8)
    tv.push_back(v(4'h0, 0, 0, PAR,  1,  R, R, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 0, PNG,  40, G, R, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 0, PNY,  5,  Y, R, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 0, PAR,  2,  R, R, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 0, PELT, 20, R, L, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 0, PEG,  40, R, G, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 0, PEY,  5,  R, Y, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 0, PAR,  2,  R, R, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 0, PNLT, 20, L, R, 2'b00, 4'h0, 0));
    // Lap 2: EW pedestrian request during NS_G extends EW_G (9..19)
    tv.push_back(v(4'h0, 0, 0, PNG,  1,  G, R, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h4, 0, 0, PNG,  1,  G, R, 2'b00, 4'h4, 0));
    tv.push_back(v(4'h0, 0, 0, PNG,  38, G, R, 2'b00, 4'h4, 0));
    tv.push_back(v(4'h0, 0, 0, PNY,  5,  Y, R, 2'b00, 4'h4, 0));
    tv.push_back(v(4'h0, 0, 0, PAR,  2,  R, R, 2'b00, 4'h4, 0));
    tv.push_back(v(4'h0, 0, 0, PELT, 20, R, L, 2'b00, 4'h4, 0));
    tv.push_back(v(4'h0, 0, 0, PEG,  50, R, G, 2'b10, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 0, PEY,  5,  R, Y, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 0, PAR,  2,  R, R, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 0, PNLT, 20, L, R, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 0, PNG,  10, G, R, 2'b00, 4'h0, 0));
    // EW preemption from NS_G (20..25)
    tv.push_back(v(4'h0, 1, 1, PNY,  5,  Y, R, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 1, 1, PAR,  2,  R, R, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 1, 1, PEMG, 3,  R, G, 2'b00, 4'h0, 1));
    tv.push_back(v(4'h0, 0, 1, PEY,  5,  R, Y, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 1, PAR,  2,  R, R, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 1, PNLT, 5,  L, R, 2'b00, 4'h0, 0));
    // NS preemption from NS_LT: EMG on the next edge (26..30)
    tv.push_back(v(4'h0, 1, 0, PEMG, 3,  G, R, 2'b00, 4'h0, 1));
    tv.push_back(v(4'h0, 0, 0, PNY,  5,  Y, R, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 0, PAR,  2,  R, R, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 0, PELT, 20, R, L, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 0, PEG,  30, R, G, 2'b00, 4'h0, 0));
    // After mid-phase reset: NS walk, then preemption aborts the walk (31..40)
    tv.push_back(v(4'h1, 0, 0, PAR,  1,  R, R, 2'b00, 4'h1, 0));
    tv.push_back(v(4'h0, 0, 0, PNG,  1,  G, R, 2'b01, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 0, PNG,  10, G, R, 2'b01, 4'h0, 0));
    tv.push_back(v(4'h0, 1, 1, PNY,  1,  Y, R, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 1, 1, PNY,  4,  Y, R, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 1, 1, PAR,  2,  R, R, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 1, 1, PEMG, 1,  R, G, 2'b00, 4'h0, 1));
    tv.push_back(v(4'h0, 0, 1, PEY,  5,  R, Y, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 1, PAR,  2,  R, R, 2'b00, 4'h0, 0));
    tv.push_back(v(4'h0, 0, 1, PNLT, 1,  L, R, 2'b00, 4'h0, 0));

    rst_exp = v(4'h0, 0, 0, PAR, 0, R, R, 2'b00, 4'h0, 0);

    rst_n   = 1'b1;
    tick    = 1'b1;
    ped_req = 4'h0;
    emg_req = 1'b0;
    emg_dir = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_outputs("reset", rst_exp);
    @(negedge clk);
    rst_n = 1'b1;

    run_range(0, 30);

    // Asynchronous reset at EW_G tick 30: outputs return without a clock edge.
    rst_n = 1'b0;
    #1 chk_outputs("async_reset", rst_exp);
    @(negedge clk);
    rst_n = 1'b1;
    run_range(31, 40);

    // Tick on every 3rd clock; a button press on a non-tick cycle still latches.
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    g_cnt = 0;
    y_cnt = 0;
    done  = 1'b0;
    for (int j = 0; j < 600 && !done; j++) begin
      tick    = (j % 3 == 0);
      ped_req = (j == 1) ? 4'h1 : 4'h0;
      @(posedge clk);
      #1;
      if (j == 1) chk("tick3 ped latch", 8'(ped_pend), 8'h01);
      if (j == 2) chk("tick3 AR held", 8'(phase), 8'(PAR));
      if (phase == PNG) begin
        if (g_cnt == 0) chk("tick3 walk", 8'(walk), 8'h01);
        g_cnt++;
      end else if (phase == PNY) begin
        y_cnt++;
      end else if (phase == PAR && y_cnt > 0) begin
        done = 1'b1;
      end
    end
    chk("tick3 done", 8'(done), 8'h01);
    chk("tick3 NS_G clocks", 8'(g_cnt), 8'd150);
    chk("tick3 NS_Y clocks", 8'(y_cnt), 8'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
